// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, clear-FSM state type and slice helper for
//               the parametrised register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Low bit of field k in a bus packing equal-width fields side by side.
    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_if.sv
// ============================================================================
// Module      : regfile_if
// Description : Write, read, clear and tap signals of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_if #(
    parameter int DATA_W = regfile_pkg::DEF_DATA_W,
    parameter int ADDR_W = $clog2(regfile_pkg::DEF_DEPTH),
    parameter int NUM_RD = regfile_pkg::DEF_NUM_RD
);
    logic                     we;
    logic [ADDR_W-1:0]        iaddr;
    logic [DATA_W-1:0]        idata;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     clr_req;
    logic                     busy;
    logic                     clr_done;
    logic [DATA_W-1:0]        rega;
    logic [DATA_W-1:0]        regb;

    modport master (
        output we, iaddr, idata, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, busy, clr_done, rega, regb
    );

    modport slave (
        input  we, iaddr, idata, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, busy, clr_done, rega, regb
    );
endinterface

`default_nettype wire

// File: rtl/regfile_rd_port.sv
// ============================================================================
// Module      : regfile_rd_port
// Description : One registered read port with range check and valid strobe.
//               REGFILE_BYPASS_EN enables write-first forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rd_port #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              rd_en,
    input  wire logic [ADDR_W-1:0] rd_addr,
    input  wire logic [DATA_W-1:0] mem [DEPTH],
    input  wire logic              fwd_en,
    input  wire logic [ADDR_W-1:0] fwd_addr,
    input  wire logic [DATA_W-1:0] fwd_data,
    output logic      [DATA_W-1:0] rd_data,
    output logic                   rd_valid
);
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic              w_in_range;
    logic [DATA_W-1:0] w_word;

    assign w_in_range = ({1'b0, rd_addr} < c_depth);

    always_comb begin
        w_word = '0;
        if (w_in_range) begin
            w_word = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
            if (fwd_en && (fwd_addr == rd_addr)) begin
                w_word = fwd_data;
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, fwd_addr, fwd_data};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= w_word;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_param.sv
// ============================================================================
// Module      : regfile_param
// Description : Parametrised register file: one write port, NUM_RD read
//               ports, entry 0/1 taps and a one-entry-per-cycle clear engine.
//               REGFILE_BYPASS_EN enables read-port write forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input wire logic clk,
    input wire logic rst,
    regfile_if.slave bus
);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              r_done, w_done_nxt;
    logic [DATA_W-1:0] r_rega, r_regb;
    logic              w_wr_ok;

    // A clear request in the same cycle wins over the write.
    assign w_wr_ok = (r_state == ST_IDLE) && !bus.clr_req && bus.we &&
                     ({1'b0, bus.iaddr} < c_depth);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_ptr == c_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.iaddr] <= bus.idata;
        end
    end

    // Taps always see pre-edge contents; they are never forwarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rega <= '0;
            r_regb <= '0;
        end else begin
            r_rega <= r_mem[0];
            r_regb <= r_mem[1];
        end
    end

    assign bus.busy     = (r_state == ST_CLEAR);
    assign bus.clr_done = r_done;
    assign bus.rega     = r_rega;
    assign bus.regb     = r_regb;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (bus.rd_en[k]),
            .rd_addr  (bus.rd_addr[slice_lo(k, ADDR_W) +: ADDR_W]),
            .mem      (r_mem),
            .fwd_en   (w_wr_ok),
            .fwd_addr (bus.iaddr),
            .fwd_data (bus.idata),
            .rd_data  (bus.rd_data[slice_lo(k, DATA_W) +: DATA_W]),
            .rd_valid (bus.rd_valid[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// Module      : tb_regfile_param
// Description : Self-checking bench for regfile_param (16 bit, 6 entries,
//               3 read ports) against a behavioural array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_param;
    localparam int DW = 16;
    localparam int DP = 6;
    localparam int NR = 3;
    localparam int AW = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_param #(.DATA_W(DW), .DEPTH(DP), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] m_mem [DP];
    logic [DW-1:0] m_data [NR];
    logic          m_valid [NR];
    logic [DW-1:0] m_rega, m_regb;
    logic          m_busy, m_done;
    int            m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
        for (int k = 0; k < NR; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
        end
        m_rega = '0;
        m_regb = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ptr  = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic          accept;
        logic [AW-1:0] a;
        accept = !m_busy && !bus.clr_req && bus.we && (int'(bus.iaddr) < DP);
        m_rega = m_mem[0];
        m_regb = m_mem[1];
        m_done = 1'b0;
        for (int k = 0; k < NR; k++) begin
            m_valid[k] = bus.rd_en[k];
            if (bus.rd_en[k]) begin
                a = bus.rd_addr[k*AW +: AW];
                m_data[k] = '0;
                if (int'(a) < DP) m_data[k] = m_mem[a];
`ifdef REGFILE_BYPASS_EN
                if (accept && a == bus.iaddr) m_data[k] = bus.idata;
`endif
            end
        end
        if (!m_busy) begin
            if (bus.clr_req) begin
                m_busy = 1'b1;
                m_ptr  = 0;
            end else if (accept) begin
                m_mem[bus.iaddr] = bus.idata;
            end
        end else begin
            m_mem[m_ptr] = '0;
            if (m_ptr == DP - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_ptr++;
            end
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(bus.busy), 32'(m_busy));
        chk("clr_done", 32'(bus.clr_done), 32'(m_done));
        chk("rega", 32'(bus.rega), 32'(m_rega));
        chk("regb", 32'(bus.regb), 32'(m_regb));
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("rd_valid%0d", k), 32'(bus.rd_valid[k]), 32'(m_valid[k]));
            chk($sformatf("rd_data%0d", k), 32'(bus.rd_data[k*DW +: DW]), 32'(m_data[k]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.we      = 1'b0;
        bus.clr_req = 1'b0;
        bus.rd_en   = '0;
    endtask

    task automatic set_rd(input int k, input int addr);
        bus.rd_en[k] = 1'b1;
        bus.rd_addr[k*AW +: AW] = AW'(addr);
    endtask

    task automatic wr(input int addr, input int data);
        bus.we    = 1'b1;
        bus.iaddr = AW'(addr);
        bus.idata = DW'(data);
        step();
        bus.we = 1'b0;
    endtask

    function automatic logic [DW-1:0] port_data(input int k);
        return bus.rd_data[k*DW +: DW];
    endfunction

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
    endtask

    int busy_cycles;
    int done_cnt;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.iaddr   = '0;
        bus.idata   = '0;
        bus.rd_addr = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Basic write then read, plus an unwritten entry.
        wr(3, 'hA5);
        set_rd(0, 3);
        set_rd(1, 5);
        step();
        idle_inputs();
        chk("basic_rd3", 32'(port_data(0)), 32'hA5);
        chk("basic_rd5", 32'(port_data(1)), 32'h0);

        // Same-edge read and write of one address.
        wr(2, 'h11);
        bus.we = 1'b1; bus.iaddr = 3'd2; bus.idata = 16'h3C;
        set_rd(1, 2);
        step();
        idle_inputs();
`ifdef REGFILE_BYPASS_EN
        chk("rw_same_edge", 32'(port_data(1)), 32'h3C);
`else
        chk("rw_same_edge", 32'(port_data(1)), 32'h11);
`endif

        // Tap latency on entry 1.
        wr(1, 'h42);
        chk("tap_old", 32'(bus.regb), 32'h0);
        step();
        chk("tap_new", 32'(bus.regb), 32'h42);

        // Out-of-range write dropped, out-of-range reads give zero.
        wr(7, 'hBEEF);
        set_rd(0, 6);
        set_rd(1, 7);
        set_rd(2, 3);
        step();
        idle_inputs();
        chk("oor_rd6", 32'(port_data(0)), 32'h0);
        chk("oor_rd7", 32'(port_data(1)), 32'h0);
        chk("oor_valid", 32'(bus.rd_valid), 32'b111);
        chk("indep_rd3", 32'(port_data(2)), 32'hA5);

        // Clear colliding with a write and a repeated request.
        for (int i = 0; i < DP; i++) wr(i, 'hFFFF);
        bus.clr_req = 1'b1; bus.we = 1'b1; bus.iaddr = 3'd0; bus.idata = 16'h77;
        step();
        idle_inputs();
        busy_cycles = bus.busy ? 1 : 0;
        done_cnt    = 0;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            bus.clr_req = (busy_cycles == 4);
            bus.rd_en   = NR'($urandom);
            bus.rd_addr = (NR*AW)'($urandom);
            step();
            if (bus.busy) busy_cycles++;
            if (bus.clr_done) done_cnt++;
        end
        idle_inputs();
        step();
        if (bus.clr_done) done_cnt++;
        chk("clear_busy_cycles", 32'(busy_cycles), 32'(DP));
        chk("clear_done_count", 32'(done_cnt), 32'd1);
        for (int i = 0; i < DP; i++) begin
            set_rd(i % NR, i);
            step();
            idle_inputs();
            chk("cleared_entry", 32'(port_data(i % NR)), 32'h0);
        end

        // Reset in the middle of a clear.
        wr(0, 'h1111);
        bus.clr_req = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        chk("mid_clear_busy", 32'(bus.busy), 32'd1);
        async_reset();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        step();
        chk("rst_no_done", 32'(bus.clr_done), 32'd0);
        wr(4, 'h1234);
        set_rd(2, 4);
        step();
        idle_inputs();
        chk("post_rst_rd", 32'(port_data(2)), 32'h1234);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bus.we      = 1'($urandom);
            bus.iaddr   = AW'($urandom);
            bus.idata   = DW'($urandom);
            bus.rd_en   = NR'($urandom);
            bus.rd_addr = (NR*AW)'($urandom);
            bus.clr_req = ($urandom_range(0, 24) == 0);
            step();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
